// File: rtl/puf_challenge_sequencer_if.sv
// puf_challenge_sequencer_if
//   Valid/ready hand-off bundle for packed PUF response words.
//   master : sequencer side, drives resp_word / resp_valid, receives resp_ready
//   slave  : consumer side, receives resp_word / resp_valid, drives resp_ready
// Signals
//   resp_word   N_RESP  packed responses, first sampled bit at bit 0
//   resp_valid  1       resp_word holds a complete word
//   resp_ready  1       consumer takes the word when valid & ready
interface puf_challenge_sequencer_if #(
  parameter int N_RESP = 32
) ();

  logic [N_RESP-1:0] resp_word;
  logic              resp_valid;
  logic              resp_ready;

  modport master (
    output resp_word,
    output resp_valid,
    input  resp_ready
  );

  modport slave (
    input  resp_word,
    input  resp_valid,
    output resp_ready
  );

endinterface

// File: rtl/puf_challenge_sequencer.sv
// puf_challenge_sequencer
//   Waits for the TRNG challenge shift register to be completely refilled,
//   latches the challenge onto the PUF, lets it settle, samples the 1-bit
//   response and packs N_RESP responses into a word that is handed off over
//   a valid/ready interface.
// Ports
//   clk            in   1      rising-edge clock
//   rst_n          in   1      asynchronous active-low reset
//   run            in   1      level, keep producing response words while high
//   C_in           in   N_CB   live challenge from the generator
//   challenge_out  out  N_CB   challenge latched for the PUF
//   puf_en         out  1      PUF evaluation enable
//   puf_resp       in   1      PUF response bit
//   busy           out  1      sequencer not idle
//   word_count     out  16     accepted words, saturating
//   resp_if        master      resp_word / resp_valid / resp_ready hand-off
module puf_challenge_sequencer #(
  parameter int N_CB   = 64,
  parameter int N_RNG  = 4,
  parameter int SETTLE = 8,
  parameter int N_RESP = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic [N_CB-1:0]           C_in,
  output logic [N_CB-1:0]           challenge_out,
  output logic                      puf_en,
  input  logic                      puf_resp,
  output logic                      busy,
  output logic [15:0]               word_count,
  puf_challenge_sequencer_if.master resp_if
);

  localparam int REFILL_CYC = N_CB / N_RNG;
  localparam int CNT_MAX    = (REFILL_CYC > SETTLE) ? REFILL_CYC : SETTLE;
  localparam int CW         = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BW         = (N_RESP > 1) ? $clog2(N_RESP) : 1;

  // Refuse to elaborate with a refill time that is not a whole number of
  // cycles or a zero settle time.
  if ((N_CB % N_RNG) != 0) begin : g_bad_rng
    $error("puf_challenge_sequencer: N_CB must be a multiple of N_RNG");
  end
  if (SETTLE < 1) begin : g_bad_settle
    $error("puf_challenge_sequencer: SETTLE must be at least 1");
  end
  if (N_RESP < 2) begin : g_bad_resp
    $error("puf_challenge_sequencer: N_RESP must be at least 2");
  end

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_REFILL = 3'd1;
  localparam logic [2:0] ST_APPLY  = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_SAMPLE = 3'd4;
  localparam logic [2:0] ST_OUTPUT = 3'd5;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bit_cnt;
  logic [N_RESP-1:0] sr;
  logic [N_RESP-1:0] sr_shift;
  logic              refill_done;
  logic              settle_done;
  logic              last_bit;

  assign refill_done = (cnt == CW'(REFILL_CYC - 1));
  assign settle_done = (cnt == CW'(SETTLE - 1));
  assign last_bit    = (bit_cnt == BW'(N_RESP - 1));

  // New bits enter at the top so the first sampled bit ends up at bit 0
  // once a full word has been shifted in.
  assign sr_shift = {puf_resp, sr[N_RESP-1:1]};

  // Next-state decision. A SAMPLE that completes the word always goes to
  // OUTPUT so the word is delivered even if run has already dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (run) state_nxt = ST_REFILL;
      ST_REFILL: if (refill_done) state_nxt = ST_APPLY;
      ST_APPLY:  state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_done) state_nxt = ST_SAMPLE;
      ST_SAMPLE: begin
        if (last_bit)  state_nxt = ST_OUTPUT;
        else if (run)  state_nxt = ST_REFILL;
        else           state_nxt = ST_IDLE;
      end
      ST_OUTPUT: if (resp_if.resp_ready) state_nxt = run ? ST_REFILL : ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // All outputs are registered. busy follows the next state so it changes
  // on the same edge as the state register. cnt is reused for both the
  // refill wait and the settle wait and always returns to zero on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= ST_IDLE;
      busy               <= 1'b0;
      cnt                <= '0;
      bit_cnt            <= '0;
      sr                 <= '0;
      challenge_out      <= '0;
      puf_en             <= 1'b0;
      word_count         <= '0;
      resp_if.resp_word  <= '0;
      resp_if.resp_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
      case (state)
        ST_IDLE: cnt <= '0;
        ST_REFILL: cnt <= refill_done ? '0 : cnt + 1'b1;
        ST_APPLY: begin
          challenge_out <= C_in;
          puf_en        <= 1'b1;
          cnt           <= '0;
        end
        ST_SETTLE: cnt <= settle_done ? '0 : cnt + 1'b1;
        ST_SAMPLE: begin
          puf_en <= 1'b0;
          cnt    <= '0;
          if (last_bit) begin
            sr                 <= sr_shift;
            resp_if.resp_word  <= sr_shift;
            resp_if.resp_valid <= 1'b1;
            bit_cnt            <= '0;
          end else if (run) begin
            sr      <= sr_shift;
            bit_cnt <= bit_cnt + 1'b1;
          end else begin
            // Stopping mid-word throws the partial word away.
            sr      <= '0;
            bit_cnt <= '0;
          end
        end
        ST_OUTPUT: begin
          if (resp_if.resp_ready) begin
            resp_if.resp_valid <= 1'b0;
            cnt                <= '0;
            if (word_count != 16'hFFFF) word_count <= word_count + 16'd1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule
